// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - data-over-fetch fixed-priority arbiter for one shared multi-cycle memory bus
// Optional ack-wait timeout abort is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ce_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [DATA_W-1:0] inst_data_o,
    output logic              inst_ready_o,
    input  logic              data_ce_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_sel_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_ready_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INST_BUSY = 2'd1,
        DATA_BUSY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] inst_data_q, inst_data_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              inst_done_q, inst_done_d;
    logic              data_done_q, data_done_d;
    logic              timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             bus_err_q, bus_err_d;

    // The counter is cleared in IDLE, so every transaction starts its wait budget from zero.
    always_comb begin
        wait_cnt_d  = (state_q == IDLE) ? '0 : wait_cnt_q + 1'b1;
        timeout_hit = (state_q != IDLE) && !bus_ack_i && (wait_cnt_q == CNT_W'(TIMEOUT - 1));
        bus_err_d   = bus_err_q | timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign bus_err_o      = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_data_d  = inst_data_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = 1'b0;
        data_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_ce_i) begin
                    bus_addr_d  = data_addr_i;
                    bus_we_d    = data_we_i;
                    bus_sel_d   = data_sel_i;
                    bus_wdata_d = data_wdata_i;
                    bus_req_d   = 1'b1;
                    state_d     = DATA_BUSY;
                end else if (inst_ce_i) begin
                    bus_addr_d = inst_addr_i;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = 4'hF;
                    bus_req_d  = 1'b1;
                    state_d    = INST_BUSY;
                end
            end
            INST_BUSY, DATA_BUSY: begin
                if (bus_ack_i) begin
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                    if (state_q == DATA_BUSY) begin
                        data_done_d = 1'b1;
                        if (!bus_we_q) data_rdata_d = bus_rdata_i;
                    end else if (inst_ce_i && (inst_addr_i == bus_addr_q)) begin
                        // A redirected or withdrawn fetch is dropped; IDLE re-issues the new address.
                        inst_done_d = 1'b1;
                        inst_data_d = bus_rdata_i;
                    end
                end else if (timeout_hit) begin
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                    if (state_q == DATA_BUSY) begin
                        data_done_d  = 1'b1;
                        data_rdata_d = '0;
                    end else begin
                        inst_done_d = 1'b1;
                        inst_data_d = '0;
                    end
                end
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= 4'h0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_data_q  <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_data_q  <= inst_data_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
        end
    end

    // An idle port with no request must read as ready so the pipeline never stalls on nothing.
    assign inst_ready_o = ((state_q == IDLE) && !inst_ce_i) ||
                          (inst_done_q && (bus_addr_q == inst_addr_i));
    assign data_ready_o = ((state_q == IDLE) && !data_ce_i) || data_done_q;

    assign inst_data_o  = inst_data_q;
    assign data_rdata_o = data_rdata_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_sel_o    = bus_sel_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one multi-cycle memory bus between the instruction-fetch port (PC stage) and the data port (MEM stage).
- Arbitrates between them with fixed priority: the data port wins over instruction fetch.
- Holds each bus transaction until the memory acknowledges it, then returns read data and a ready indication to the winning port.
- The fetch port's ready feeds the PC stage stall request; the data port's ready feeds the MEM stage stall request.

Parameters:
- ADDR_W, 32, width of instruction, data and bus addresses.
- DATA_W, 32, width of read/write data.
- TIMEOUT, 255, ack-wait cycle limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_ce_i  in  1  fetch request, level.
- inst_addr_i  in  ADDR_W  fetch address.
- inst_data_o  out  DATA_W  fetched word.
- inst_ready_o  out  1  fetch port not stalled.
- data_ce_i  in  1  data request, level.
- data_we_i  in  1  1 = write.
- data_sel_i  in  4  byte enables.
- data_addr_i  in  ADDR_W  data address.
- data_wdata_i  in  DATA_W  write data.
- data_rdata_o  out  DATA_W  read data.
- data_ready_o  out  1  data port not stalled.
- bus_req_o  out  1  bus cycle active.
- bus_we_o  out  1  bus write.
- bus_sel_o  out  4  bus byte enables.
- bus_addr_o  out  ADDR_W  bus address.
- bus_wdata_o  out  DATA_W  bus write data.
- bus_rdata_i  in  DATA_W  bus read data.
- bus_ack_i  in  1  bus cycle complete, one-cycle pulse.
- bus_err_o  out  1  timeout flag; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0; state IDLE; latched owner and address cleared.
- States: IDLE, INST_BUSY, DATA_BUSY.
- IDLE transitions:
  - data_ce_i=1: latch data_addr/we/sel/wdata onto the bus regs, set bus_req_o=1, go to DATA_BUSY.
  - else inst_ce_i=1: latch inst_addr_i, set bus_we_o=0 and bus_sel_o=4'hF, set bus_req_o=1, go to INST_BUSY.
  - Both requests asserted in the same cycle: data wins; fetch waits.
- BUSY states:
  - Bus outputs are held stable until bus_ack_i.
  - On bus_ack_i: register bus_rdata_i into the owner's rdata output, drop bus_req_o, pulse the done flag for one cycle, return to IDLE.
  - One idle turnaround cycle separates back-to-back transactions.
- Latency: request seen in IDLE at cycle N gives bus_req_o=1 from N+1; ack at cycle M gives ready at M+1.
- inst_ready_o is combinational and high when either holds:
  - state==IDLE and inst_ce_i==0 (no fetch pending; prevents a stall deadlock);
  - the fetch-done pulse is active and the latched address equals the current inst_addr_i.
- Fetch address changes mid-transaction (branch/flush):
  - The completion is discarded: no ready, and inst_data_o is not updated.
  - The fetch is re-issued from IDLE with the new address.
- data_ready_o is high when either holds:
  - state==IDLE and data_ce_i==0;
  - the data-done pulse is active.
- Data requests are never discarded.
- Writes: data_rdata_o is unchanged on write completion.
- inst_data_o and data_rdata_o hold their values between completions.
- Ack outside BUSY: ignored.
- Request deasserted while BUSY: the transaction still completes and its result is dropped.
- Reset mid-operation: bus_req_o drops asynchronously and the FSM returns to IDLE; any later ack is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider wait counter counts BUSY cycles and clears on each new transaction.
  - When the count reaches TIMEOUT without ack, the FSM aborts: bus_req_o=0, bus_err_o=1 (sticky until reset), the owner's ready pulses once with rdata=0, state goes to IDLE.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o tied 0.

Test Plan:
- Single fetch: inst_ce=1, addr=0x00000004; ack after 3 cycles with rdata=0x3C011234 → inst_data_o=0x3C011234, inst_ready_o high exactly one cycle, bus_we_o=0, bus_sel_o=F.
- Simultaneous: inst_ce=1 addr 0x10 and data_ce=1 read 0x80 → bus_addr_o=0x80 first, then 0x10 after one idle cycle; data_ready_o precedes inst_ready_o.
- Write: data_ce=1, we=1, sel=4'b0011, addr=0x100, wdata=0xDEADBEEF → bus fields match while held; data_ready_o pulses; data_rdata_o unchanged.
- Branch abort: fetch 0x20 in flight, inst_addr changes to 0x40 before ack → no inst_ready_o for 0x20; a new bus cycle is issued at 0x40 and its result is delivered.
- Reset: assert rst while DATA_BUSY → bus_req_o=0 immediately (asynchronously); an ack arriving after reset has no effect.
- ARB_TIMEOUT_EN, TIMEOUT=8, no ack → bus_err_o=1 after 8 BUSY cycles; owner ready pulses with rdata=0; FSM returns to IDLE.
